// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file and its clear engine.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  // Widest data path the merge helper handles; callers size-cast in and out.
  localparam int MAX_W = 512;

  function automatic logic [MAX_W-1:0] merge_bytes(input logic [MAX_W-1:0]   old_v,
                                                   input logic [MAX_W-1:0]   new_v,
                                                   input logic [MAX_W/8-1:0] be);
    logic [MAX_W-1:0] r;
    for (int i = 0; i < MAX_W/8; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/clear bus between the register file and its requester.
interface regfile_mp_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              rd_en_a;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [WIDTH-1:0]  rd_data_a;
  logic              rd_en_b;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH/8-1:0] wr_be;
  logic              wr_ready;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output wr_en, wr_addr, wr_data, wr_be, clr_req,
    input  rd_data_a, rd_data_b, wr_ready, clr_busy, clr_done
  );

  modport slave (
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  wr_en, wr_addr, wr_data, wr_be, clr_req,
    output rd_data_a, rd_data_b, wr_ready, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_clr_fsm.sv
// Bulk-clear sequencer: sweeps one entry per cycle and gates writes while busy.
//   state | meaning
//   IDLE  | writes accepted, waiting for clr_req
//   CLEAR | zeroing entry[cnt], writes blocked
//   DONE  | one-cycle completion pulse, writes accepted
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              clr_req_i,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic              wr_ready_o,
  output logic [ADDR_W-1:0] clr_cnt_o
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_busy_o = 1'b0;
    clr_done_o = 1'b0;
    wr_ready_o = 1'b1;
    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        clr_busy_o = 1'b1;
        wr_ready_o = 1'b0;
        // Counter wraps back to 0 on the last entry since DEPTH is a power of two.
        cnt_d      = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = DONE;
      end
      DONE: begin
        clr_done_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: byte-enable writes, two registered read ports,
// optional zero entry and write bypass, plus a sequential bulk clear.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic        clk,
  input  logic        Reset,
  regfile_mp_if.slave bus
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  rd_data_a_q, rd_data_a_d;
  logic [WIDTH-1:0]  rd_data_b_q, rd_data_b_d;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic              clr_busy;
  logic              wr_ready;
  logic              wr_acc;
  logic [WIDTH-1:0]  wr_merged;

  regfile_clr_fsm #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clr (
    .clk        (clk),
    .Reset      (Reset),
    .clr_req_i  (bus.clr_req),
    .clr_busy_o (clr_busy),
    .clr_done_o (bus.clr_done),
    .wr_ready_o (wr_ready),
    .clr_cnt_o  (clr_cnt)
  );

  assign bus.clr_busy = clr_busy;
  assign bus.wr_ready = wr_ready;
  assign wr_addr      = bus.wr_addr;

  // Writes to the hardwired zero entry are treated as never accepted.
  assign wr_acc    = bus.wr_en && wr_ready && !(ZERO_REG != 0 && wr_addr == '0);
  assign wr_merged = WIDTH'(merge_bytes(MAX_W'(mem_q[wr_addr]), MAX_W'(bus.wr_data),
                                        (MAX_W/8)'(bus.wr_be)));

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_busy) begin
      mem_q[clr_cnt] <= '0;
    end else if (wr_acc) begin
      mem_q[wr_addr] <= wr_merged;
    end
  end

  function automatic logic [WIDTH-1:0] rd_value(input logic [ADDR_W-1:0] addr);
    if (ZERO_REG != 0 && addr == '0)                return '0;
    if (BYPASS != 0 && clr_busy && addr == clr_cnt) return '0;
    if (BYPASS != 0 && wr_acc && addr == wr_addr)   return wr_merged;
    return mem_q[addr];
  endfunction

  always_comb begin
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (bus.rd_en_a) rd_data_a_d = rd_value(bus.rd_addr_a);
    if (bus.rd_en_b) rd_data_b_d = rd_value(bus.rd_addr_b);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
    end
  end

  assign bus.rd_data_a = rd_data_a_q;
  assign bus.rd_data_b = rd_data_b_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a bypassing instance and a non-bypassing twin
// share one stimulus stream; read expectations are queued when issued.
module tb_regfile_mp;

  localparam int W = 32;
  localparam int D = 32;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  regfile_mp_if #(.WIDTH(W), .DEPTH(D)) rif ();
  regfile_mp_if #(.WIDTH(W), .DEPTH(D)) nif ();

  assign nif.rd_en_a   = rif.rd_en_a;
  assign nif.rd_addr_a = rif.rd_addr_a;
  assign nif.rd_en_b   = rif.rd_en_b;
  assign nif.rd_addr_b = rif.rd_addr_b;
  assign nif.wr_en     = rif.wr_en;
  assign nif.wr_addr   = rif.wr_addr;
  assign nif.wr_data   = rif.wr_data;
  assign nif.wr_be     = rif.wr_be;
  assign nif.clr_req   = rif.clr_req;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .Reset(Reset), .bus(rif.slave));
  regfile_mp #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .Reset(Reset), .bus(nif.slave));

  typedef struct {
    string       tag;
    logic [31:0] exp;
    int          port;   // 0: A, 1: B, 2: A of the non-bypassing twin
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [D];
  int          ms;       // 0 idle, 1 clearing, 2 done
  int          mcnt;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] tb_merge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (n & mask) | (o & ~mask);
  endfunction

  function automatic logic [31:0] exp_rd(input int addr, input bit byp, input bit wacc,
                                         input int wa, input logic [31:0] merged);
    if (addr == 0) return 32'h0;
    if (byp && ms == 1 && addr == mcnt) return 32'h0;
    if (byp && wacc && wa == addr) return merged;
    return mem[addr];
  endfunction

  task automatic push(input string tag, input logic [31:0] exp, input int port);
    exp_t e;
    e.tag = tag; e.exp = exp; e.port = port;
    sb_q.push_back(e);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < D; i++) mem[i] = 32'h0;
    ms = 0;
    mcnt = 0;
  endfunction

  // One clock: queue expectations from current inputs, advance model, then compare.
  task automatic step();
    int          wa;
    bit          wacc;
    logic [31:0] merged;
    exp_t        e;
    wa     = int'(rif.wr_addr);
    wacc   = rif.wr_en && ms != 1 && wa != 0;
    merged = tb_merge(mem[wa], rif.wr_data, rif.wr_be);
    if (rif.rd_en_a) begin
      push("rdA", exp_rd(int'(rif.rd_addr_a), 1'b1, wacc, wa, merged), 0);
      push("rdA_nobyp", exp_rd(int'(rif.rd_addr_a), 1'b0, wacc, wa, merged), 2);
    end
    if (rif.rd_en_b) push("rdB", exp_rd(int'(rif.rd_addr_b), 1'b1, wacc, wa, merged), 1);
    if (wacc) mem[wa] = merged;
    if (ms == 1) begin
      mem[mcnt] = 32'h0;
      if (mcnt == D - 1) ms = 2;
      mcnt = (mcnt + 1) % D;
    end else if (ms == 2) begin
      ms = 0;
    end else if (rif.clr_req) begin
      ms = 1;
      mcnt = 0;
    end
    @(posedge clk);
    #1;
    chk("clr_busy", 32'(rif.clr_busy), 32'(ms == 1));
    chk("clr_done", 32'(rif.clr_done), 32'(ms == 2));
    chk("wr_ready", 32'(rif.wr_ready), 32'(ms != 1));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.port)
        0:       chk(e.tag, rif.rd_data_a, e.exp);
        1:       chk(e.tag, rif.rd_data_b, e.exp);
        default: chk(e.tag, nif.rd_data_a, e.exp);
      endcase
    end
  endtask

  task automatic idle_inputs();
    rif.rd_en_a = 1'b0; rif.rd_addr_a = '0;
    rif.rd_en_b = 1'b0; rif.rd_addr_b = '0;
    rif.wr_en = 1'b0; rif.wr_addr = '0; rif.wr_data = '0; rif.wr_be = '0;
    rif.clr_req = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    rif.wr_en = 1'b1; rif.wr_addr = 5'(a); rif.wr_data = d; rif.wr_be = be;
    step();
    rif.wr_en = 1'b0;
  endtask

  task automatic rd(input int a, input int b);
    rif.rd_en_a = 1'b1; rif.rd_addr_a = 5'(a);
    rif.rd_en_b = 1'b1; rif.rd_addr_b = 5'(b);
    step();
    rif.rd_en_a = 1'b0; rif.rd_en_b = 1'b0;
  endtask

  initial begin
    int busy_cnt, done_cnt, ready_bad;
    Reset = 1'b1;
    idle_inputs();
    model_reset();
    #12;
    chk("rst_rd_a", rif.rd_data_a, 32'h0);
    chk("rst_rd_b", rif.rd_data_b, 32'h0);
    chk("rst_busy", 32'(rif.clr_busy), 32'h0);
    chk("rst_ready", 32'(rif.wr_ready), 32'h1);
    Reset = 1'b0;

    for (int a = 0; a < D; a++) rd(a, D - 1 - a);

    wr(5, 32'h1234_5678, 4'hF);
    wr(5, 32'hFFFF_AAFF, 4'b0010);
    wr(5, 32'hDEAD_BEEF, 4'h0);
    rd(5, 5);
    chk("merge_addr5", rif.rd_data_a, 32'h1234_AA78);

    wr(7, 32'h0BAD_F00D, 4'hF);
    rif.rd_en_a = 1'b1; rif.rd_addr_a = 5'd7;
    wr(7, 32'h89AB_CDEF, 4'hF);
    chk("bypass_on", rif.rd_data_a, 32'h89AB_CDEF);
    chk("bypass_off", nif.rd_data_a, 32'h0BAD_F00D);
    wr(7, 32'h0000_0000, 4'b0001);
    rif.rd_en_a = 1'b0;

    wr(0, 32'hFFFF_FFFF, 4'hF);
    wr(31, 32'hFFFF_FFFF, 4'hF);
    rd(0, 31);
    chk("zero_reg", rif.rd_data_a, 32'h0);
    chk("addr31", rif.rd_data_b, 32'hFFFF_FFFF);

    for (int a = 0; a < D; a++) wr(a, 32'h7FFF_FFFF, 4'hF);
    busy_cnt = 0; done_cnt = 0; ready_bad = 0;
    rif.clr_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 3) rif.clr_req = 1'b0;
      rif.rd_en_a = 1'b1; rif.rd_addr_a = 5'(c);
      rif.rd_en_b = 1'b1; rif.rd_addr_b = 5'(c + 7);
      if (c == 17) begin
        rif.wr_en = 1'b1; rif.wr_addr = 5'd3; rif.wr_data = 32'h5555_5555; rif.wr_be = 4'hF;
      end else begin
        rif.wr_en = 1'b0;
      end
      step();
      if (rif.clr_busy) busy_cnt++;
      if (rif.clr_busy && rif.wr_ready) ready_bad++;
      if (rif.clr_done) done_cnt++;
    end
    idle_inputs();
    chk("busy_cycles", 32'(busy_cnt), 32'd32);
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("ready_in_clear", 32'(ready_bad), 32'd0);
    rd(3, 30);
    chk("post_clr_3", rif.rd_data_a, 32'h0);
    for (int a = 0; a < D; a++) rd(a, a);

    wr(9, 32'h1111_2222, 4'hF);
    rif.clr_req = 1'b1;
    step();
    rif.clr_req = 1'b0;
    for (int c = 0; c < 9; c++) step();
    #1 Reset = 1'b1;
    #1;
    model_reset();
    chk("midrst_busy", 32'(rif.clr_busy), 32'h0);
    chk("midrst_done", 32'(rif.clr_done), 32'h0);
    chk("midrst_ready", 32'(rif.wr_ready), 32'h1);
    chk("midrst_rd_a", rif.rd_data_a, 32'h0);
    #1 Reset = 1'b0;
    wr(9, 32'hCAFE_0001, 4'hF);
    rd(9, 10);
    chk("after_rst_wr", rif.rd_data_a, 32'hCAFE_0001);
    for (int a = 0; a < D; a++) rd(a, D - 1 - a);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
